ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the ALU and drives its ain, bin and alu_op inputs.
- Accepts decoded instructions over a valid/ready handshake and resolves source operands by forwarding from the EX/MEM and MEM/WB stages.
- Selects the immediate or rs2 for bin, and registers the result.
- A 2-entry skid buffer keeps id_ready a registered signal.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all held instructions (branch/exception redirect)
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage can accept an instruction
id_rs1_addr  in  RA_W  source 1 register index
id_rs2_addr  in  RA_W  source 2 register index
id_rs1_data  in  XLEN  register-file value for rs1
id_rs2_data  in  XLEN  register-file value for rs2
id_imm  in  XLEN  sign-extended immediate
id_use_imm  in  1  1: bin = imm, 0: bin = rs2 operand
id_alu_op  in  3  ALU operation code, passed through unchanged
id_rd_addr  in  RA_W  destination register
id_reg_write  in  1  instruction writes rd
exmem_rd  in  RA_W  EX/MEM destination
exmem_reg_write  in  1  EX/MEM writes rd
exmem_result  in  XLEN  EX/MEM result
memwb_rd  in  RA_W  MEM/WB destination
memwb_reg_write  in  1  MEM/WB writes rd
memwb_result  in  XLEN  MEM/WB result
ex_valid  out  1  ALU inputs hold a valid instruction
ex_ready  in  1  execute consumes the instruction this cycle
ain  out  XLEN  ALU operand A
bin  out  XLEN  ALU operand B
alu_op  out  3  ALU operation code
ex_rd_addr  out  RA_W  destination register, to EX/MEM
ex_reg_write  out  1  write enable, to EX/MEM

Behaviour:
- Reset (rst_n low, asynchronous): ex_valid=0, skid buffer empty, id_ready=1. ain, bin, alu_op, ex_rd_addr and ex_reg_write are all 0.
- Forwarding (combinational, evaluated in the acceptance cycle):
  - For each source s: if exmem_reg_write and exmem_rd==s_addr and s_addr!=0, the operand is exmem_result.
  - Else if memwb_reg_write and memwb_rd==s_addr and s_addr!=0, the operand is memwb_result.
  - Else the operand is id_rs*_data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand selection: bin = id_use_imm ? id_imm : the forwarded rs2 operand. Forwarding of rs2 still applies when id_use_imm=0.
- Handshake:
  - A transfer occurs on a rising edge with id_valid && id_ready (accept), or ex_valid && ex_ready (consume).
  - id_ready = !skid_valid, and is a registered flag.
  - Main register empty, or consumed in the same cycle: the accepted instruction loads the main register directly. Latency is 1 cycle from accept to ex_valid.
  - Main register full and not consumed: the accepted instruction goes to the skid entry, and id_ready drops in the next cycle.
  - Skid full and main consumed: the skid entry moves to main, and id_ready rises in the next cycle.
- Output hold: all ex_* outputs, ain, bin and alu_op hold stable while ex_valid && !ex_ready.
- Forwarded values are captured at acceptance. Held entries are not re-forwarded. Hazard detection upstream guarantees correctness.
- Flush:
  - Synchronous. At the next edge ex_valid=0, the skid is empty and id_ready=1.
  - An accept in the same cycle as flush is dropped.
  - Flush overrides a simultaneous consume; the consume still completes downstream.
  - Data registers may retain stale values.
- Invalid outputs: when ex_valid=0, ex_reg_write is forced to 0.
- No ordering violation: instructions leave in acceptance order. The skid never overflows, because id_ready=0 whenever the skid is full.

Test Plan:
- Reset, then accept rs1=x3 (0x10), rs2=x4 (0x20), alu_op=000, no hazards, ex_ready=1 -> next cycle ex_valid=1, ain=0x10, bin=0x20, alu_op=000.
- exmem_rd=3, exmem_reg_write=1, exmem_result=0xAA. memwb_rd=3, memwb_reg_write=1, memwb_result=0xBB. Accept rs1=x3 -> ain=0xAA. Repeat with exmem_reg_write=0 -> ain=0xBB.
- rs1=x0 with exmem_rd=0, exmem_reg_write=1, exmem_result=0xFF, id_rs1_data=0 -> ain=0. Accept id_use_imm=1, id_imm=0xFFFFFFFC with rs2 forwarded -> bin=0xFFFFFFFC.
- Hold ex_ready=0 and offer 3 back-to-back instructions A, B, C:
  - A goes to main and B to skid; id_ready=0, so C is not accepted.
  - Raise ex_ready -> A then B then C appear in order, with outputs stable while stalled.
- Main and skid full, assert flush with id_valid=1 -> next cycle ex_valid=0, id_ready=1, and the new instruction is not present.
- Drop rst_n mid-stream with a full skid, asynchronously between edges -> outputs go to 0 and ex_valid=0 immediately, with id_ready=1.

Source files
------------

// File: rtl/ex_operand_stage.sv
// Operand stage in front of the ALU: resolves rs1/rs2 by forwarding, picks imm or rs2 for bin,
// and registers the result behind a valid/ready handshake with a one-entry skid for a registered id_ready.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [2:0]      id_alu_op,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic            id_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ain,
    output logic [XLEN-1:0] bin,
    output logic [2:0]      alu_op,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_write
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      op;
        logic [RA_W-1:0] rd;
        logic            rw;
    } entry_t;

    // EX/MEM wins over MEM/WB; x0 is hardwired and never forwarded.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] rf_data,
        input logic            em_we,
        input logic [RA_W-1:0] em_rd,
        input logic [XLEN-1:0] em_res,
        input logic            mw_we,
        input logic [RA_W-1:0] mw_rd,
        input logic [XLEN-1:0] mw_res
    );
        if (addr != '0 && em_we && em_rd == addr) begin
            return em_res;
        end else if (addr != '0 && mw_we && mw_rd == addr) begin
            return mw_res;
        end
        return rf_data;
    endfunction

    logic   ex_valid_q, ex_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   id_ready_q, id_ready_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    logic   accept;
    logic   consume;
    logic   main_free;
    logic [XLEN-1:0] rs2_fwd;

    always_comb begin
        rs2_fwd = fwd_operand(id_rs2_addr, id_rs2_data, exmem_reg_write, exmem_rd,
                              exmem_result, memwb_reg_write, memwb_rd, memwb_result);
        new_entry.a  = fwd_operand(id_rs1_addr, id_rs1_data, exmem_reg_write, exmem_rd,
                                   exmem_result, memwb_reg_write, memwb_rd, memwb_result);
        new_entry.b  = id_use_imm ? id_imm : rs2_fwd;
        new_entry.op = id_alu_op;
        new_entry.rd = id_rd_addr;
        new_entry.rw = id_reg_write;
    end

    assign accept    = id_valid && id_ready_q && !flush;
    assign consume   = ex_valid_q && ex_ready;
    assign main_free = !ex_valid_q || consume;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            ex_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // id_ready is low while the skid is occupied, so no accept can happen here.
            if (consume) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_free) begin
                main_d     = new_entry;
                ex_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end else if (consume) begin
            ex_valid_d = 1'b0;
        end
        id_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            id_ready_q   <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            skid_valid_q <= skid_valid_d;
            id_ready_q   <= id_ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign id_ready     = id_ready_q;
    assign ex_valid     = ex_valid_q;
    assign ain          = main_q.a;
    assign bin          = main_q.b;
    assign alu_op       = main_q.op;
    assign ex_rd_addr   = main_q.rd;
    assign ex_reg_write = ex_valid_q && main_q.rw;

endmodule
